mc_controller_ext: RTL and testbench

Multicycle control unit for the ARM-subset datapath, replacing the single-mode controller. Combines the main state machine, the instruction decoder and the conditional-execution logic, and adds a variable-latency multiply path: a start/done handshake with a watchdog, and an optional second write-back cycle for 64-bit long multiplies. Sits between the instruction register and the datapath muxes, register file, memory-enable and PC-enable.

---
 rtl/mc_controller_ext.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_controller_ext.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_ext.sv
// Multicycle ARM-subset control unit: main FSM, instruction decoder, conditional execution,
// and a variable-latency multiply path with watchdog and optional high-word write-back.
module mc_controller_ext #(
   parameter int unsigned MUL_TIMEOUT = 32,
   parameter logic        LONG_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [27:0] Instr,
   input  logic [3:0]  Rd,
   input  logic [3:0]  ALUFlags,
   input  logic        MulDone,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [3:0]  ALUControl,
   output logic        MulStart,
   output logic        WbHi,
   output logic        MulErr,
   output logic [3:0]  state
);

   localparam int unsigned CW = $clog2(MUL_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR   = 4'd6,  S_EXECI  = 4'd7,
      S_ALUWB   = 4'd8,  S_BRANCH = 4'd9,  S_MULWAIT = 4'd10, S_ALUWB2 = 4'd11
   } state_t;

   state_t          cur_state, nxt_state;
   logic [3:0]      flags;
   logic            cond_ex, cond_ex_reg;
   logic [CW-1:0]   wait_cnt;
   logic            timeout;

   // Instr carries bits [31:4] of the instruction word, so full bit b sits at Instr[b-4].
   logic [3:0] cond;
   logic [1:0] op;
   logic       ibit, sbit, b23, b22;
   logic [3:0] cmd;
   logic       is_mul, is_long, rd15;
   logic [3:0] dp_alu, mul_alu, op_alu;
   logic       dp_arith, dp_cmp, dp_nz_w, dp_cv_w, alu_wr;
   logic       unused_bits;

   assign cond        = Instr[27:24];
   assign op          = Instr[23:22];
   assign ibit        = Instr[21];
   assign cmd         = Instr[20:17];
   assign sbit        = Instr[16];
   assign b23         = Instr[19];
   assign b22         = Instr[18];
   assign unused_bits = ^Instr[15:4];

   assign is_mul  = (op == 2'b00) && !ibit && (Instr[3:0] == 4'b1001);
   assign is_long = is_mul && b23 && LONG_EN;
   assign mul_alu = is_long ? (b22 ? 4'b0110 : 4'b0101) : 4'b0100;
   assign rd15    = (Rd == 4'hF);

   always_comb begin
      dp_alu   = 4'b0000;
      dp_arith = 1'b0;
      dp_cmp   = 1'b0;
      unique case (cmd)
         4'b0100: begin dp_alu = 4'b0000; dp_arith = 1'b1; end
         4'b0010: begin dp_alu = 4'b0001; dp_arith = 1'b1; end
         4'b0000: dp_alu = 4'b0010;
         4'b1100: dp_alu = 4'b0011;
         4'b1010: begin dp_alu = 4'b0001; dp_arith = 1'b1; dp_cmp = 1'b1; end
         default: dp_alu = 4'b0000;
      endcase
   end

   assign dp_nz_w = sbit || dp_cmp;
   assign dp_cv_w = dp_nz_w && dp_arith;
   assign op_alu  = is_mul ? mul_alu : dp_alu;
   assign alu_wr  = is_mul || !dp_cmp;

   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags;
      unique case (cond)
         4'h0: cond_ex = z;
         4'h1: cond_ex = !z;
         4'h2: cond_ex = c;
         4'h3: cond_ex = !c;
         4'h4: cond_ex = n;
         4'h5: cond_ex = !n;
         4'h6: cond_ex = v;
         4'h7: cond_ex = !v;
         4'h8: cond_ex = c && !z;
         4'h9: cond_ex = !c || z;
         4'hA: cond_ex = (n == v);
         4'hB: cond_ex = (n != v);
         4'hC: cond_ex = !z && (n == v);
         4'hD: cond_ex = z || (n != v);
         4'hE: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign timeout = (wait_cnt == CW'(MUL_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur_state <= S_FETCH;
      else        cur_state <= nxt_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags       <= '0;
         cond_ex_reg <= 1'b0;
         wait_cnt    <= '0;
         MulErr      <= 1'b0;
      end else begin
         if (cur_state == S_DECODE) cond_ex_reg <= cond_ex;
         wait_cnt <= (cur_state == S_MULWAIT) ? wait_cnt + CW'(1) : '0;
         if (cur_state == S_MULWAIT && !MulDone && timeout) MulErr <= 1'b1;
         if (cond_ex_reg) begin
            if (cur_state == S_EXECR || cur_state == S_EXECI) begin
               if (dp_nz_w) flags[3:2] <= ALUFlags[3:2];
               if (dp_cv_w) flags[1:0] <= ALUFlags[1:0];
            end else if (cur_state == S_ALUWB && is_mul && sbit) begin
               flags[3:2] <= ALUFlags[3:2];
            end
         end
      end
   end

   always_comb begin
      nxt_state = cur_state;
      unique case (cur_state)
         S_FETCH:   nxt_state = S_DECODE;
         S_DECODE: begin
            if      (op == 2'b01) nxt_state = S_MEMADR;
            else if (op == 2'b10) nxt_state = S_BRANCH;
            else if (is_mul)      nxt_state = S_MULWAIT;
            else if (ibit)        nxt_state = S_EXECI;
            else                  nxt_state = S_EXECR;
         end
         S_MEMADR:  nxt_state = sbit ? S_MEMRD : S_MEMWR;
         S_MEMRD:   nxt_state = S_MEMWB;
         S_EXECR,
         S_EXECI:   nxt_state = S_ALUWB;
         S_ALUWB:   nxt_state = is_long ? S_ALUWB2 : S_FETCH;
         // MulDone takes priority over an expiring watchdog in the same cycle.
         S_MULWAIT: begin
            if      (MulDone) nxt_state = S_ALUWB;
            else if (timeout) nxt_state = S_FETCH;
         end
         default:   nxt_state = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 4'b0000;
      MulStart   = 1'b0;
      WbHi       = 1'b0;
      unique case (cur_state)
         S_FETCH: begin
            IRWrite = 1'b1; PCWrite = 1'b1;
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            MulStart = is_mul;
         end
         S_MEMADR:  ALUSrcB = 2'b01;
         S_MEMRD:   AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex_reg;
            PCWrite   = cond_ex_reg && rd15;
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex_reg;
         end
         S_EXECR:   ALUControl = op_alu;
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = op_alu;
         end
         S_MULWAIT: ALUControl = op_alu;
         S_ALUWB: begin
            ALUControl = op_alu;
            RegWrite   = cond_ex_reg && alu_wr;
            PCWrite    = cond_ex_reg && alu_wr && rd15;
         end
         S_ALUWB2: begin
            ALUControl = op_alu;
            RegWrite   = cond_ex_reg;
            WbHi       = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
            PCWrite = cond_ex_reg;
         end
         default: ;
      endcase
   end

   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign ImmSrc = op;
   assign state  = cur_state;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Bench for mc_controller_ext: directed test-plan steps plus random instruction streams,
// checked cycle by cycle against a path/effect model of the instruction set.
module tb_mc_controller_ext;

   localparam int unsigned TMO = 4;
   localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MWR = 4'd5,
                          XR = 4'd6, XI = 4'd7, AWB = 4'd8, BR = 4'd9, MW = 4'd10, AW2 = 4'd11;
   localparam int C_DP = 0, C_LDR = 1, C_STR = 2, C_B = 3, C_MUL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, sel_nl;
   logic [27:0] instr;
   logic [3:0]  rd_i, alu_flags;
   logic        mul_done;

   logic        pcw_a, memw_a, regw_a, irw_a, adr_a, ms_a, hi_a, err_a;
   logic [1:0]  srca_a, srcb_a, res_a, unused_regsrc_a, unused_imm_a;
   logic [3:0]  aluc_a, st_a;
   logic        pcw_b, memw_b, regw_b, irw_b, adr_b, ms_b, hi_b, err_b;
   logic [1:0]  srca_b, srcb_b, res_b, unused_regsrc_b, unused_imm_b;
   logic [3:0]  aluc_b, st_b;

   logic        o_pcw, o_memw, o_regw, o_irw, o_adr, o_ms, o_hi, o_err;
   logic [1:0]  o_srca, o_srcb, o_res;
   logic [3:0]  o_aluc, o_st;

   mc_controller_ext #(.MUL_TIMEOUT(TMO), .LONG_EN(1'b1)) dut (
      .clk(clk), .reset(rst_a), .Instr(instr), .Rd(rd_i), .ALUFlags(alu_flags), .MulDone(mul_done),
      .PCWrite(pcw_a), .MemWrite(memw_a), .RegWrite(regw_a), .IRWrite(irw_a), .AdrSrc(adr_a),
      .RegSrc(unused_regsrc_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .ResultSrc(res_a),
      .ImmSrc(unused_imm_a), .ALUControl(aluc_a), .MulStart(ms_a), .WbHi(hi_a), .MulErr(err_a),
      .state(st_a));

   mc_controller_ext #(.MUL_TIMEOUT(TMO), .LONG_EN(1'b0)) dut_nl (
      .clk(clk), .reset(rst_b), .Instr(instr), .Rd(rd_i), .ALUFlags(alu_flags), .MulDone(mul_done),
      .PCWrite(pcw_b), .MemWrite(memw_b), .RegWrite(regw_b), .IRWrite(irw_b), .AdrSrc(adr_b),
      .RegSrc(unused_regsrc_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .ResultSrc(res_b),
      .ImmSrc(unused_imm_b), .ALUControl(aluc_b), .MulStart(ms_b), .WbHi(hi_b), .MulErr(err_b),
      .state(st_b));

   always_comb begin
      o_pcw  = sel_nl ? pcw_b  : pcw_a;
      o_memw = sel_nl ? memw_b : memw_a;
      o_regw = sel_nl ? regw_b : regw_a;
      o_irw  = sel_nl ? irw_b  : irw_a;
      o_adr  = sel_nl ? adr_b  : adr_a;
      o_ms   = sel_nl ? ms_b   : ms_a;
      o_hi   = sel_nl ? hi_b   : hi_a;
      o_err  = sel_nl ? err_b  : err_a;
      o_srca = sel_nl ? srca_b : srca_a;
      o_srcb = sel_nl ? srcb_b : srcb_a;
      o_res  = sel_nl ? res_b  : res_a;
      o_aluc = sel_nl ? aluc_b : aluc_a;
      o_st   = sel_nl ? st_b   : st_a;
   end

   int unsigned n_chk = 0, n_err = 0;
   logic [3:0]  m_flags;
   logic        m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;            4'h1: return !z;
         4'h2: return cy;           4'h3: return !cy;
         4'h4: return n;            4'h5: return !n;
         4'h6: return v;            4'h7: return !v;
         4'h8: return cy && !z;     4'h9: return !cy || z;
         4'hA: return n == v;       4'hB: return n != v;
         4'hC: return !z && n == v; 4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] enc_dp(input logic [3:0] cond, input logic imm, input logic [3:0] cmd,
                                          input logic s, input logic [3:0] rd, input logic [11:0] op2);
      logic [11:0] o;
      o = op2;
      if (!imm) o[4] = 1'b0;
      return {cond, 2'b00, imm, cmd, s, 4'h2, rd, o};
   endfunction

   function automatic logic [31:0] enc_mem(input logic [3:0] cond, input logic [3:0] puBw, input logic ld,
                                           input logic [3:0] rd, input logic [11:0] off);
      return {cond, 2'b01, 1'b0, puBw, ld, 4'h3, rd, off};
   endfunction

   function automatic logic [31:0] enc_b(input logic [3:0] cond, input logic [23:0] imm);
      return {cond, 3'b101, 1'b0, imm};
   endfunction

   function automatic logic [31:0] enc_mul(input logic [3:0] cond, input logic lng, input logic sgn,
                                           input logic s, input logic [3:0] rd);
      return {cond, 4'b0000, lng, sgn, 1'b0, s, 4'h7, rd, 4'h5, 4'b1001, 4'h6};
   endfunction

   // Runs one instruction from its FETCH cycle to the next FETCH; entered at posedge+1 of FETCH.
   task automatic do_instr(input logic [31:0] w, input logic [3:0] rd, input logic [3:0] fl,
                           input int unsigned k);
      logic [3:0] path[$];
      logic [3:0] st, cmd, exp_alu;
      int         cat;
      logic       c, lng, tmo, wr, cmp, arith, s;
      int unsigned mw;
      cmd = w[24:21];
      s   = w[20];
      if (w[27:26] == 2'b01)                    cat = w[20] ? C_LDR : C_STR;
      else if (w[27:26] == 2'b10)               cat = C_B;
      else if (!w[25] && w[7:4] == 4'b1001)     cat = C_MUL;
      else                                      cat = C_DP;
      lng   = (cat == C_MUL) && w[23] && !sel_nl;
      cmp   = (cat == C_DP) && cmd == 4'b1010;
      arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
      case (cmd)
         4'b0100: exp_alu = 4'b0000;
         4'b0010: exp_alu = 4'b0001;
         4'b0000: exp_alu = 4'b0010;
         4'b1100: exp_alu = 4'b0011;
         default: exp_alu = 4'b0001;
      endcase
      if (cat == C_MUL) exp_alu = lng ? (w[22] ? 4'b0110 : 4'b0101) : 4'b0100;
      c   = cond_pass(w[31:28], m_flags);
      wr  = (cat == C_LDR) || (cat == C_MUL) || (cat == C_DP && !cmp);
      tmo = (cat == C_MUL) && (k >= TMO);
      path = {F, D};
      case (cat)
         C_LDR: begin path.push_back(MA); path.push_back(MR); path.push_back(MWB); end
         C_STR: begin path.push_back(MA); path.push_back(MWR); end
         C_B:   path.push_back(BR);
         C_DP:  begin path.push_back(w[25] ? XI : XR); path.push_back(AWB); end
         default: begin
            for (int unsigned j = 0; j < (tmo ? TMO : k + 1); j++) path.push_back(MW);
            if (!tmo) path.push_back(AWB);
            if (!tmo && lng) path.push_back(AW2);
         end
      endcase
      instr = w[31:4]; rd_i = rd; alu_flags = fl; mw = 0;
      foreach (path[i]) begin
         st = path[i];
         if (st == MW) begin mul_done = (mw >= k); mw++; end
         else mul_done = 1'($urandom_range(0, 1));
         #1;
         chk("state", 32'(o_st), 32'(st));
         chk("IRWrite", 32'(o_irw), 32'(st == F));
         chk("PCWrite", 32'(o_pcw), 32'(st == F || (st == BR && c) ||
                                       ((st == AWB || st == MWB) && rd == 4'hF && wr && c)));
         chk("RegWrite", 32'(o_regw), 32'(c && (st == MWB || (st == AWB && wr) || st == AW2)));
         chk("MemWrite", 32'(o_memw), 32'(c && st == MWR));
         chk("MulStart", 32'(o_ms), 32'(st == D && cat == C_MUL));
         chk("WbHi", 32'(o_hi), 32'(st == AW2));
         chk("MulErr", 32'(o_err), 32'(m_err));
         if (st == F) begin
            chk("fetch_mux", 32'({o_adr, o_srca, o_srcb, o_res}), 32'({1'b0, 2'b01, 2'b10, 2'b10}));
         end
         if (st == XR || st == XI || st == MW) chk("ALUControl", 32'(o_aluc), 32'(exp_alu));
         @(posedge clk); #1;
      end
      if (tmo) m_err = 1'b1;
      if (c && cat == C_DP && (s || cmp)) begin
         m_flags[3:2] = fl[3:2];
         if (arith) m_flags[1:0] = fl[1:0];
      end
      if (c && cat == C_MUL && !tmo && s) m_flags[3:2] = fl[3:2];
   endtask

   task automatic rand_instr();
      logic [3:0] cond, rd, cmd;
      logic [3:0] cmds [5];
      logic [31:0] w;
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
      rd   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
         0, 1: begin
            cmd = cmds[$urandom_range(0, 4)];
            if (cmd == 4'b1010) rd = rd & 4'hE;
            w = enc_dp(cond, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)), rd,
                       12'($urandom));
         end
         2: w = enc_mem(cond, 4'($urandom), 1'($urandom_range(0, 1)), rd, 12'($urandom));
         3: w = enc_b(cond, 24'($urandom));
         default: w = enc_mul(cond, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), rd);
      endcase
      do_instr(w, rd, 4'($urandom), $urandom_range(0, 6));
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; sel_nl = 1'b0;
      instr = '0; rd_i = '0; alu_flags = '0; mul_done = 1'b1;
      m_flags = '0; m_err = 1'b0;
      #3;
      chk("rst_state", 32'(o_st), 32'(F));
      chk("rst_ctrl", 32'({o_irw, o_pcw, o_memw, o_regw, o_ms, o_hi, o_err}), 32'(7'b1100000));
      @(posedge clk); #1;
      rst_a = 1'b1;

      do_instr(enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 12'd5), 4'd1, 4'h0, 0);   // ADD R1,R2,#5
      do_instr(enc_dp(4'hE, 1'b0, 4'b0010, 1'b1, 4'd3, 12'h004), 4'd3, 4'b0100, 0); // SUBS -> Z
      do_instr(enc_dp(4'h1, 1'b0, 4'b0100, 1'b1, 4'd4, 12'h004), 4'd4, 4'b0000, 0); // ADDNES skipped
      do_instr(enc_dp(4'h0, 1'b1, 4'b0100, 1'b0, 4'd5, 12'd1), 4'd5, 4'h0, 0);    // ADDEQ, Z kept
      do_instr(enc_mem(4'hE, 4'b1100, 1'b1, 4'hF, 12'h010), 4'hF, 4'h0, 0);       // LDR PC
      do_instr(enc_mem(4'hE, 4'b1100, 1'b0, 4'd2, 12'h020), 4'd2, 4'h0, 0);       // STR
      do_instr(enc_b(4'hE, 24'h000010), 4'd0, 4'h0, 0);
      do_instr(enc_b(4'hF, 24'h000010), 4'd0, 4'h0, 0);                           // never
      do_instr(enc_mul(4'hE, 1'b0, 1'b0, 1'b0, 4'd4), 4'd4, 4'h0, 3);             // MulDone wins
      do_instr(enc_mul(4'hE, 1'b1, 1'b0, 1'b1, 4'd6), 4'd6, 4'b1000, 0);          // UMULLS
      do_instr(enc_mul(4'hE, 1'b1, 1'b1, 1'b0, 4'd6), 4'd6, 4'h0, 2);             // SMULL
      do_instr(enc_mul(4'hE, 1'b0, 1'b0, 1'b0, 4'd4), 4'd4, 4'h0, 100);           // timeout
      do_instr(enc_dp(4'hE, 1'b1, 4'b1100, 1'b0, 4'd1, 12'd3), 4'd1, 4'h0, 0);    // MulErr sticky

      // Reset in the middle of a multiply wait.
      instr = enc_mul(4'hE, 1'b0, 1'b0, 1'b0, 4'd2) >> 4; mul_done = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_mul_state", 32'(o_st), 32'(MW));
      rst_a = 1'b0; #1;
      chk("mid_rst_state", 32'(o_st), 32'(F));
      chk("mid_rst_err", 32'(o_err), 32'(0));
      m_err = 1'b0; m_flags = '0;
      @(posedge clk); #1;
      rst_a = 1'b1;
      do_instr(enc_mul(4'hE, 1'b0, 1'b0, 1'b1, 4'd2), 4'd2, 4'b0100, 1);

      for (int i = 0; i < 200; i++) rand_instr();

      rst_a = 1'b0; sel_nl = 1'b1; rst_b = 1'b1;
      m_flags = '0; m_err = 1'b0;
      do_instr(enc_mul(4'hE, 1'b1, 1'b0, 1'b0, 4'd6), 4'd6, 4'h0, 0);             // no ALUWB2
      do_instr(enc_mul(4'hE, 1'b1, 1'b1, 1'b1, 4'd6), 4'd6, 4'b0100, 2);
      do_instr(enc_mul(4'hE, 1'b0, 1'b0, 1'b0, 4'd6), 4'd6, 4'h0, 5);
      for (int i = 0; i < 30; i++) rand_instr();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
